word_slice_sched: RTL and testbench

- Sequencing controller for the 16-bit word-to-byte slicing datapath.
- Accepts 16-bit words over a valid/ready handshake and buffers them in a small FIFO.
- Emits bytes over a second valid/ready handshake, primary byte first.
- Primary byte uses the slice rule: if word[15] & word[8] then word[7:0], else word[15:8]. Optionally the complementary byte follows. Sits between a word producer and a byte-wide consumer.

---
 rtl/word_slice_sched_if.sv | 26 ++
 rtl/word_slice_sched.sv | 133 +++++++++++++
 tb/tb_word_slice_sched.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/word_slice_sched_if.sv
// Handshake bundle for word_slice_sched: 16-bit word input side, byte output side
// and status.
interface word_slice_sched_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             cfg_pair;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;
  logic             busy;
  logic [CNT_W-1:0] words_done;

  modport slave (
    input  in_valid, in_data, cfg_pair, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, words_done
  );

  modport master (
    output in_valid, in_data, cfg_pair, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, words_done
  );
endinterface

// File: rtl/word_slice_sched.sv
// Word-to-byte slicing scheduler: small input FIFO feeding a FIRST/SECOND byte FSM,
// with registered outputs and a completed-word counter.
module word_slice_sched #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  word_slice_sched_if.slave   bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FIRST  = 2'd1;
  localparam logic [1:0] ST_SECOND = 2'd2;

  logic [15:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic [1:0]       state_q, state_d;
  logic [15:0]      word_q, word_d;
  logic             swap_q, swap_d, pair_q, pair_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [CNT_W-1:0] words_done_q, words_done_d;

  logic        push, pop, out_hs, word_done, head_swap;
  logic [15:0] head;

  always_comb begin
    push      = bus.in_valid & in_ready_q;
    out_hs    = out_valid_q & bus.out_ready;
    word_done = out_hs & out_last_q;
    // A finishing word hands over to the next FIFO entry on the same edge.
    pop       = (count_q != '0) & ((state_q == ST_IDLE) | word_done);
    head      = mem_q[rd_ptr_q];
    head_swap = head[15] & head[8];

    state_d      = state_q;
    word_d       = word_q;
    swap_d       = swap_q;
    pair_d       = pair_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    words_done_d = word_done ? words_done_q + CNT_W'(1) : words_done_q;

    case (state_q)
      ST_FIRST: begin
        if (out_hs && pair_q) begin
          state_d    = ST_SECOND;
          out_data_d = swap_q ? word_q[15:8] : word_q[7:0];
          out_last_d = 1'b1;
        end else if (word_done) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
      ST_SECOND: begin
        if (word_done) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
      default: ;
    endcase

    if (pop) begin
      state_d     = ST_FIRST;
      word_d      = head;
      swap_d      = head_swap;
      pair_d      = bus.cfg_pair;
      out_valid_d = 1'b1;
      out_data_d  = head_swap ? head[7:0] : head[15:8];
      out_last_d  = ~bus.cfg_pair;
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d != FullCnt);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      in_ready_q   <= 1'b0;
      state_q      <= ST_IDLE;
      word_q       <= '0;
      swap_q       <= 1'b0;
      pair_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      words_done_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      in_ready_q   <= in_ready_d;
      state_q      <= state_d;
      word_q       <= word_d;
      swap_q       <= swap_d;
      pair_q       <= pair_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      words_done_q <= words_done_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.busy       = (count_q != '0) | (state_q != ST_IDLE);
  assign bus.words_done = words_done_q;
endmodule

// File: tb/tb_word_slice_sched.sv
// Self-checking bench for word_slice_sched: directed scenarios plus random traffic,
// all compared each cycle against a queue-based byte-stream model.
module tb_word_slice_sched;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  word_slice_sched_if #(.CNT_W(CNT_W)) bus ();

  word_slice_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: words waiting in the FIFO, and the bytes still owed for the word in flight.
  logic [15:0]      m_fifo [$];
  logic [7:0]       m_byte [$];
  bit               m_last [$];
  logic [CNT_W-1:0] m_done;
  bit               m_rdy;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_byte.delete();
    m_last.delete();
    m_done = '0;
    m_rdy  = 1'b0;
  endtask

  task automatic model_update();
    bit          out_hs, in_hs, swap;
    int          pre_size;
    logic [15:0] w;
    out_hs   = (m_byte.size() > 0) && bus.out_ready;
    in_hs    = bus.in_valid && m_rdy;
    pre_size = m_fifo.size();
    if (out_hs) begin
      if (m_last[0]) m_done = m_done + 1'b1;
      void'(m_byte.pop_front());
      void'(m_last.pop_front());
    end
    if (m_byte.size() == 0 && pre_size > 0) begin
      w    = m_fifo.pop_front();
      swap = w[15] && w[8];
      m_byte.push_back(swap ? w[7:0] : w[15:8]);
      m_last.push_back(!bus.cfg_pair);
      if (bus.cfg_pair) begin
        m_byte.push_back(swap ? w[15:8] : w[7:0]);
        m_last.push_back(1'b1);
      end
    end
    if (in_hs) m_fifo.push_back(bus.in_data);
    m_rdy = (m_fifo.size() != DEPTH);
  endtask

  task automatic check_all();
    chk("in_ready", {15'd0, bus.in_ready}, {15'd0, m_rdy});
    chk("out_valid", {15'd0, bus.out_valid}, {15'd0, m_byte.size() > 0});
    if (m_byte.size() > 0) begin
      chk("out_data", {8'd0, bus.out_data}, {8'd0, m_byte[0]});
      chk("out_last", {15'd0, bus.out_last}, {15'd0, m_last[0]});
    end
    chk("busy", {15'd0, bus.busy}, {15'd0, (m_fifo.size() > 0) || (m_byte.size() > 0)});
    chk("words_done", {12'd0, bus.words_done}, {12'd0, m_done});
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_out_data", {8'd0, bus.out_data}, 16'd0);
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b1;
    cycle();
  endtask

  task automatic push_word(input logic [15:0] w, input bit pair);
    bit hs;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    bus.cfg_pair = pair;
    hs = 1'b0;
    for (int i = 0; i < 50 && !hs; i++) begin
      hs = bus.in_ready;
      cycle();
    end
    if (!hs) chk("push_timeout", 16'd0, 16'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100 && (m_fifo.size() > 0 || m_byte.size() > 0); i++) cycle();
    chk("drain_idle", {15'd0, bus.busy}, 16'd0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.cfg_pair  = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Pair mode, swapped word.
    push_word(16'h8155, 1'b1);
    drain();
    chk("done_after_8155", {12'd0, bus.words_done}, 16'd1);

    // Pair mode, back-to-back words.
    bus.cfg_pair = 1'b1;
    push_word(16'h8055, 1'b1);
    push_word(16'h0123, 1'b1);
    drain();
    chk("done_after_pair2", {12'd0, bus.words_done}, 16'd3);

    // Single mode, swap then no swap.
    push_word(16'hFF3C, 1'b0);
    push_word(16'h7F3C, 1'b0);
    drain();

    // Backpressure: fill the FIFO while the consumer stalls.
    bus.out_ready = 1'b0;
    push_word(16'h1111, 1'b1);
    push_word(16'h2222, 1'b1);
    push_word(16'h3333, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h4444;
    repeat (3) cycle();
    chk("full_in_ready", {15'd0, bus.in_ready}, 16'd0);
    bus.out_ready = 1'b1;
    push_word(16'h4444, 1'b1);
    drain();

    // Reset in the middle of a paired word.
    push_word(16'hABCD, 1'b1);
    cycle();
    cycle();
    do_reset();
    chk("post_rst_done", {12'd0, bus.words_done}, 16'd0);
    push_word(16'h0102, 1'b1);
    drain();

    // Counter wrap: 17 single-byte words.
    bus.cfg_pair = 1'b0;
    for (int i = 0; i < 17; i++) push_word(16'($urandom), 1'b0);
    drain();

    // Random traffic, including mid-word cfg_pair changes.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 16'($urandom);
      bus.cfg_pair  = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.in_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
